// File: rtl/waxwing_test_1.sv
// Waxwing 8-bit accumulator CPU test-build top: single-cycle core, 32-entry demo ROM,
// 2-flop switch synchronizer and LED register. Optional WAXWING_SLOWCLK_EN adds a step prescaler.
module waxwing_test_1 #(
   parameter int PRESCALE_BITS = 24
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic [6:0] Switch,
   output logic [7:0] LED
);

   typedef enum logic [2:0] {
      OP_LDI  = 3'b000,
      OP_ADDI = 3'b001,
      OP_IN   = 3'b010,
      OP_OUT  = 3'b011,
      OP_JMP  = 3'b100,
      OP_JZ   = 3'b101,
      OP_SUBI = 3'b110,
      OP_XORI = 3'b111
   } op_e;

   logic [4:0] pc_q, pc_d;
   logic [7:0] a_q, a_d;
   logic [7:0] led_q, led_d;
   logic [6:0] sw_s1_q, sw_s2_q;
   logic       step_en;
   logic [7:0] instr;
   op_e        op;
   logic [7:0] arg8;

   // Echo switches; all-off shows 8'h1F. Unused slots jump home.
   function automatic logic [7:0] rom_rd(input logic [4:0] addr);
      logic [7:0] w;
      case (addr)
         5'd0:    w = {OP_IN,  5'd0};
         5'd1:    w = {OP_JZ,  5'd4};
         5'd2:    w = {OP_OUT, 5'd0};
         5'd3:    w = {OP_JMP, 5'd0};
         5'd4:    w = {OP_LDI, 5'd31};
         5'd5:    w = {OP_OUT, 5'd0};
         5'd6:    w = {OP_JMP, 5'd0};
         default: w = 8'h80;
      endcase
      return w;
   endfunction

`ifdef WAXWING_SLOWCLK_EN
   logic [PRESCALE_BITS-1:0] cnt_q;

   // The CPU steps on the edge where the counter rolls over to zero.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_q + {{(PRESCALE_BITS-1){1'b0}}, 1'b1};
   end

   assign step_en = &cnt_q;
`else
   if (PRESCALE_BITS < 1) begin : g_prescale_range
   end

   assign step_en = 1'b1;
`endif

   assign instr = rom_rd(pc_q);
   assign op    = op_e'(instr[7:5]);
   assign arg8  = {3'b000, instr[4:0]};

   always_comb begin
      pc_d  = pc_q + 5'd1;
      a_d   = a_q;
      led_d = led_q;
      case (op)
         OP_LDI:  a_d = arg8;
         OP_ADDI: a_d = a_q + arg8;
         OP_IN:   a_d = {1'b0, sw_s2_q};
         OP_OUT:  led_d = a_q;
         OP_JMP:  pc_d = instr[4:0];
         OP_JZ:   if (a_q == 8'h00) pc_d = instr[4:0];
         OP_SUBI: a_d = a_q - arg8;
         OP_XORI: a_d = a_q ^ arg8;
         default: ;
      endcase
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         pc_q    <= '0;
         a_q     <= '0;
         led_q   <= '0;
         sw_s1_q <= '0;
         sw_s2_q <= '0;
      end else begin
         sw_s1_q <= Switch;
         sw_s2_q <= sw_s1_q;
         if (step_en) begin
            pc_q  <= pc_d;
            a_q   <= a_d;
            led_q <= led_d;
         end
      end
   end

   assign LED = led_q;

endmodule

// File: tb/tb_waxwing_test_1.sv
// Scoreboard bench for waxwing_test_1: expected LED values are queued when switches are
// driven and popped when the LED settles; LED[7] is watched throughout.
module tb_waxwing_test_1;

   logic       Clk;
   logic       Rst_n;
   logic [6:0] Switch;
   logic [7:0] LED;

   int n_cmp;
   int n_bad;
   bit led7_seen;
   int clk_cnt;
   logic [7:0] exp_q[$];

   waxwing_test_1 #(.PRESCALE_BITS(4)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Switch(Switch), .LED(LED)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always @(negedge Clk) if (LED[7] === 1'b1) led7_seen = 1'b1;

   // Wait until LED equals the target or the edge budget runs out; no judgement here.
   task automatic wait_led(input logic [7:0] tgt, input int max_edges,
                           output logic [7:0] got, output int edges);
      edges = 0;
      got   = LED;
      while (edges < max_edges && LED !== tgt) begin
         @(posedge Clk); #1;
         edges++;
      end
      got = LED;
   endtask

   task automatic test_reset();
      Rst_n  = 1'b0;
      Switch = 7'h00;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         n_cmp++;
         if (LED !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_hold cyc%0d: LED=%h want 00", i, LED);
         end
      end
   endtask

   task automatic test_zero();
      logic [7:0] got, e;
      int edges;
      Switch = 7'h00;
      exp_q.push_back(8'h1F);
      @(negedge Clk); Rst_n = 1'b1;
      wait_led(8'h1F, 12, got, edges);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++;
         $display("FAIL zero_path: LED=%h want %h after %0d edges", got, e, edges);
      end
      repeat (30) @(posedge Clk);
      #1;
      n_cmp++;
      if (LED !== 8'h1F) begin
         n_bad++;
         $display("FAIL zero_stable: LED=%h want 1f", LED);
      end
   endtask

   task automatic test_echo();
      logic [7:0] got, e;
      int edges;
      logic [6:0] pats[2];
      pats[0] = 7'h2A;
      pats[1] = 7'h7F;
      foreach (pats[k]) begin
         @(negedge Clk);
         Switch = pats[k];
         exp_q.push_back({1'b0, pats[k]});
         wait_led({1'b0, pats[k]}, 10, got, edges);
         e = exp_q.pop_front();
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL echo_%h: LED=%h want %h after %0d edges", pats[k], got, e, edges);
         end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] got;
      int edges;
      @(negedge Clk);
      Switch = 7'h2A;
      wait_led(8'h2A, 10, got, edges);
      n_cmp++;
      if (got !== 8'h2A) begin
         n_bad++;
         $display("FAIL async_pre: LED=%h want 2a", got);
      end
      @(negedge Clk);
      #1 Rst_n = 1'b0;
      #1;
      n_cmp++;
      if (LED !== 8'h00) begin
         n_bad++;
         $display("FAIL async_reset: LED=%h want 00 without edge", LED);
      end
      @(negedge Clk); Rst_n = 1'b1;
   endtask

   task automatic test_toggle();
      logic [7:0] got, e;
      int edges;
      logic [6:0] seq[3];
      seq[0] = 7'h01;
      seq[1] = 7'h00;
      seq[2] = 7'h55;
      foreach (seq[k]) begin
         @(negedge Clk);
         Switch = seq[k];
         e = (seq[k] == 7'h00) ? 8'h1F : {1'b0, seq[k]};
         exp_q.push_back(e);
         wait_led(e, 12, got, edges);
         e = exp_q.pop_front();
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL toggle_%0d: LED=%h want %h after %0d edges", k, got, e, edges);
         end
      end
   endtask

   task automatic test_midloop_reset();
      logic [7:0] got, e;
      int edges;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      Rst_n  = 1'b0;
      Switch = 7'h33;
      @(negedge Clk);
      Rst_n = 1'b1;
      exp_q.push_back(8'h33);
      wait_led(8'h33, 10, got, edges);
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
         n_bad++;
         $display("FAIL midloop_restart: LED=%h want %h after %0d edges", got, e, edges);
      end
   endtask

   task automatic test_led7();
      n_cmp++;
      if (led7_seen !== 1'b0) begin
         n_bad++;
         $display("FAIL led7_zero: seen=%b want 0", led7_seen);
      end
   endtask

   task automatic test_slowclk();
      logic [7:0] prev;
      int t;
      Rst_n  = 1'b0;
      Switch = 7'h2A;
      @(negedge Clk); Rst_n = 1'b1;
      prev = LED;
      t = 0;
      while (t < 160 && LED !== 8'h2A) begin
         @(posedge Clk); #1;
         t++;
         if (LED !== prev) begin
            n_cmp++;
            if ((t % 16) != 0) begin
               n_bad++;
               $display("FAIL slow_edge: LED changed at clock %0d, want multiple of 16", t);
            end
            prev = LED;
         end
      end
      n_cmp++;
      if (LED !== 8'h2A) begin
         n_bad++;
         $display("FAIL slow_reach: LED=%h want 2a within 160 clocks", LED);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      led7_seen = 1'b0;
      Rst_n = 1'b0;
      Switch = 7'h00;
      clk_cnt = 0;
      test_reset();
`ifdef WAXWING_SLOWCLK_EN
      test_slowclk();
`else
      test_zero();
      test_echo();
      test_async_reset();
      test_toggle();
      test_midloop_reset();
`endif
      test_led7();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/waxwing_test_1.md
# waxwing_test_1

Board-level top for the Waxwing 8-bit accumulator CPU test build. It contains a single-cycle CPU core, a 32-entry instruction ROM holding a fixed demo program, a 2-flop switch synchronizer, and an 8-bit LED output register. The program echoes the 7 slide switches onto the LEDs, and shows a fixed pattern when all switches are off. It sits directly under the FPGA pin constraints; there is no other logic above it.

## Interface
- `PRESCALE_BITS`, default 24: width of the step-enable prescaler counter. Used only when `WAXWING_SLOWCLK_EN` is defined.
- `Clk` input, 1 bit: system clock. All state is clocked on the rising edge.
- `Rst_n` input, 1 bit: one clock; reset is asynchronous and active-low.
- `Switch` input, 7 bits: asynchronous slide switches.
- `LED` output, 8 bits: registered LED port.

## Operation
- Internal state:
  - `PC`: 5 bits.
  - `A`: 8-bit accumulator.
  - `LED` register: 8 bits.
  - `sw_s1`, `sw_s2`: 7-bit synchronizer stages.
  - Prescaler counter: only when the macro is enabled.
- Instruction format: 8 bits, `op[7:5]`, `arg[4:0]`. `ROM[PC]` is read combinationally.
- Instruction set:
  - 000 LDI: `A = {3'b0, arg}`.
  - 001 ADDI: `A = A + {3'b0, arg}`, modulo 256 (wraps, no carry kept).
  - 010 IN: `A = {1'b0, sw_s2}`.
  - 011 OUT: `LED = A`.
  - 100 JMP: `PC = arg`.
  - 101 JZ: `PC = arg` if `A == 0`; otherwise `PC + 1`.
  - 110 SUBI: `A = A - {3'b0, arg}`, modulo 256.
  - 111 XORI: `A = A ^ {3'b0, arg}`.
- Every non-jump instruction sets `PC = PC + 1`, modulo 32. `PC` wraps from 31 to 0.
- Demo program in the ROM:
  - 0: IN
  - 1: JZ 4
  - 2: OUT
  - 3: JMP 0
  - 4: LDI 31
  - 5: OUT
  - 6: JMP 0
  - 7–31: all `8'h80` (JMP 0).
- Net behaviour:
  - Any nonzero `Switch` value is echoed, so `LED = {1'b0, Switch}`.
  - `Switch == 0` gives `LED = 8'h1F`.
  - `LED[7]` is always 0 with this program.
- Reset (`Rst_n` low) forces, immediately and without waiting for a clock edge:
  - `PC = 0`, `A = 0`, `LED = 8'h00`, `sw_s1 = sw_s2 = 0`.
  - Prescaler counter = 0.
- Reset asserted mid-program aborts the current instruction. Execution restarts at ROM[0] on the first enabled edge after release.

## Timing
- One instruction executes per enabled rising edge (single-cycle). Without the macro, every edge is enabled.
- Switch path latency is 2 edges through the synchronizer. IN reads `sw_s2`.
- OUT updates `LED` on the edge that executes it. `LED` holds its value between OUT instructions.
- Worst-case `Switch` change to `LED` update, with no prescaler:
  - Synchronizer: 2 edges.
  - Then up to one full 4-instruction loop, plus IN, JZ and OUT: at most 10 edges.
  - Zero path (LDI 31, OUT): at most 12 edges.
- No handshakes. A `Switch` change mid-loop is picked up on the next IN.

## Configuration
- `WAXWING_SLOWCLK_EN` defined:
  - A `PRESCALE_BITS`-wide free-running counter runs on `Clk`.
  - The CPU steps (PC, A, LED update) only on the edge where the counter wraps to 0, i.e. once every 2^`PRESCALE_BITS` clocks.
  - The synchronizer still runs every clock.
- `WAXWING_SLOWCLK_EN` undefined: no prescaler is built, and the CPU steps on every `Clk` edge.

## Test plan
- Reset: with `Rst_n = 0` and `Clk` toggling, `LED = 8'h00`. Assert `Rst_n` low between edges while `LED = 8'h2A` -> `LED` goes to 0 with no clock edge.
- `Switch = 0`, release reset -> `LED = 8'h1F` within 12 edges and stable thereafter.
- `Switch = 7'h2A` after reset -> `LED = 8'h2A` within 10 edges. Then `Switch = 7'h7F` -> `LED = 8'h7F` within 10 edges.
- `Switch` from `7'h01` to `0` -> `LED` goes from `8'h01` to `8'h1F` within 12 edges. Back to `7'h55` -> `LED = 8'h55`.
- Reset released mid-loop (`Switch = 7'h33`) -> restart from PC 0 and `LED = 8'h33` within 10 edges. Check that `LED[7]` is never 1 in any scenario.
- With `WAXWING_SLOWCLK_EN` and `PRESCALE_BITS = 4`, `Switch = 7'h2A` -> `LED` changes only on clocks that are multiples of 16 and reaches `8'h2A` within 10×16 clocks.
